// File: rtl/exec_unit_mc.sv
// exec_unit_mc: registered execute-stage unit with an 8-op ALU, an iterative
// shift-add multiplier, registered {C,N,Z} flags and valid/ready handshakes.
// Results and Address are sign-extended to OUT_WIDTH.
module exec_unit_mc #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 ALU,
  input  logic [2:0]           ALUOp,
  input  logic [WIDTH-1:0]     Data1,
  input  logic [WIDTH-1:0]     Data2,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [OUT_WIDTH-1:0] DataOut,
  output logic [OUT_WIDTH-1:0] Address,
  output logic [2:0]           Flags
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_mul_d1;
  logic [SW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_data_out;
  logic [OUT_WIDTH-1:0] r_addr;
  logic [2:0]           r_flags;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_load_single;
  logic                 w_start_mul;
  logic                 w_mul_done;
  logic                 w_alu_c;
  logic [WIDTH-1:0]     w_alu_res;
  logic [WIDTH-1:0]     w_result;
  logic [WIDTH-1:0]     w_acc_next;
  logic [SW-1:0]        w_shamt;

  function automatic logic [OUT_WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return OUT_WIDTH'($signed(v));
  endfunction

  assign w_shamt    = Data2[SW-1:0];
  assign w_is_mul   = ALU && (ALUOp == 3'b111);
  assign w_result   = ALU ? w_alu_res : Data2;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign InReady    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && OutReady);
  assign w_accept   = InValid && InReady && !Flush;
  assign OutValid   = (r_state == ST_HOLD);
  assign DataOut    = r_data_out;
  assign Address    = r_addr;
  assign Flags      = r_flags;

  // Single-cycle ALU result and carry; carry defaults to the held C flag.
  always_comb begin
    w_alu_c   = r_flags[2];
    w_alu_res = '0;
    case (ALUOp)
      3'b000: {w_alu_c, w_alu_res} = {1'b0, Data1} + {1'b0, Data2};
      3'b001: w_alu_res = ~Data1;
      3'b010: {w_alu_c, w_alu_res} = {1'b0, Data1} - {1'b0, Data2};
      3'b011: w_alu_res = Data1 & Data2;
      3'b100: w_alu_res = Data1 | Data2;
      // Widening by one bit captures the last bit shifted out as the carry.
      3'b101: begin
        {w_alu_c, w_alu_res} = {1'b0, Data1} << w_shamt;
        if (w_shamt == '0) w_alu_c = r_flags[2];
      end
      3'b110: begin
        {w_alu_res, w_alu_c} = {Data1, 1'b0} >> w_shamt;
        if (w_shamt == '0) w_alu_c = r_flags[2];
      end
      default: w_alu_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and load strobes; Flush overrides everything.
  always_comb begin
    w_next        = r_state;
    w_load_single = 1'b0;
    w_start_mul   = 1'b0;
    w_mul_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin w_next = ST_MUL;  w_start_mul   = 1'b1; end
          else          begin w_next = ST_HOLD; w_load_single = 1'b1; end
        end
      end
      ST_MUL: begin
        if (r_cnt == SW'(WIDTH - 1)) begin
          w_next     = ST_HOLD;
          w_mul_done = 1'b1;
        end
      end
      ST_HOLD: begin
        if (OutReady) begin
          if (w_accept) begin
            if (w_is_mul) begin w_next = ST_MUL;  w_start_mul   = 1'b1; end
            else          begin w_next = ST_HOLD; w_load_single = 1'b1; end
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (Flush) begin
      w_next        = ST_IDLE;
      w_load_single = 1'b0;
      w_start_mul   = 1'b0;
      w_mul_done    = 1'b0;
    end
  end

  // Output/flag registers and the one-bit-per-cycle multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_addr     <= '0;
      r_flags    <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_mul_d1   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_load_single) begin
        r_data_out <= sext(w_result);
        r_addr     <= sext(Data1);
        if (ALU) r_flags <= {w_alu_c, w_alu_res[WIDTH-1], w_alu_res == '0};
      end
      if (w_start_mul) begin
        r_mcand  <= Data1;
        r_mplier <= Data2;
        r_mul_d1 <= Data1;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if ((r_state == ST_MUL) && !Flush) begin
        r_acc    <= w_acc_next;
        r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_mul_done) begin
        r_data_out <= sext(w_acc_next);
        r_addr     <= sext(r_mul_d1);
        r_flags    <= {r_flags[2], w_acc_next[WIDTH-1], w_acc_next == '0};
      end
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Self-checking bench for exec_unit_mc: WIDTH=16/OUT_WIDTH=32 main instance
// plus a WIDTH=8/OUT_WIDTH=16 instance. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_exec_unit_mc;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  flags;
  } exp_t;

  typedef struct packed {
    logic        alu;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, alu, out_ready;
  logic [2:0]  op;
  logic [15:0] d1, d2;
  logic        in_ready, out_valid;
  logic [31:0] data_out, address;
  logic [2:0]  flags;

  logic        b_flush, b_in_valid, b_alu, b_out_ready;
  logic [2:0]  b_op;
  logic [7:0]  b_d1, b_d2;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_data_out, b_address;
  logic [2:0]  b_flags;

  exp_t        sb[$];
  logic [2:0]  m_flags;
  logic [31:0] last_data;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  exec_unit_mc #(.WIDTH(16), .OUT_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid),
    .InReady(in_ready), .ALU(alu), .ALUOp(op), .Data1(d1), .Data2(d2),
    .OutValid(out_valid), .OutReady(out_ready), .DataOut(data_out),
    .Address(address), .Flags(flags)
  );

  exec_unit_mc #(.WIDTH(8), .OUT_WIDTH(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .Flush(b_flush), .InValid(b_in_valid),
    .InReady(b_in_ready), .ALU(b_alu), .ALUOp(b_op), .Data1(b_d1), .Data2(b_d2),
    .OutValid(b_out_valid), .OutReady(b_out_ready), .DataOut(b_data_out),
    .Address(b_address), .Flags(b_flags)
  );

  // Reference model for the 16-bit unit; updates m_flags like the hardware.
  function automatic void model(input logic a_alu, input logic [2:0] a_op,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r);
    int unsigned ua, ub, sh;
    logic c;
    ua = 32'(a);
    ub = 32'(b);
    sh = 32'(b[3:0]);
    c  = m_flags[2];
    r  = 16'h0;
    if (!a_alu) begin
      r = b;
      return;
    end
    case (a_op)
      3'd0: begin r = 16'(ua + ub); c = (ua + ub) > 32'd65535; end
      3'd1: r = ~a;
      3'd2: begin r = 16'(ua - ub); c = ua < ub; end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: begin r = 16'(ua << sh); if (sh != 0) c = ((ua >> (16 - sh)) & 1) != 0; end
      3'd6: begin r = 16'(ua >> sh); if (sh != 0) c = ((ua >> (sh - 1)) & 1) != 0; end
      default: r = 16'(ua * ub);
    endcase
    m_flags = {c, r[15], r == 16'h0};
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() == 0) e = 'x;
    else                e = sb.pop_front();
    return e;
  endfunction

  task automatic drive_op(input logic a_alu, input logic [2:0] a_op,
                          input logic [15:0] a, input logic [15:0] b, input bit record);
    logic [15:0] r;
    exp_t e;
    in_valid = 1'b1; alu = a_alu; op = a_op; d1 = a; d2 = b;
    if (record) begin
      model(a_alu, a_op, a, b, r);
      e.data  = {{16{r[15]}}, r};
      e.addr  = {{16{a[15]}}, a};
      e.flags = m_flags;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset valid: got %b expected 0", out_valid); end
    n_checks++; if (data_out !== 32'h0) begin n_errors++; $display("FAIL reset data: got %h expected 0", data_out); end
    n_checks++; if (address !== 32'h0) begin n_errors++; $display("FAIL reset addr: got %h expected 0", address); end
    n_checks++; if (flags !== 3'b000) begin n_errors++; $display("FAIL reset flags: got %b expected 000", flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    stim_t tbl[10];
    exp_t  e;
    tbl = '{ '{1'b1, 3'd0, 16'h7FFF, 16'h0001}, '{1'b1, 3'd2, 16'h0003, 16'h0005},
             '{1'b1, 3'd1, 16'hFFFF, 16'h0000}, '{1'b1, 3'd3, 16'hF0F0, 16'h0FF0},
             '{1'b1, 3'd4, 16'h8000, 16'h0001}, '{1'b1, 3'd5, 16'h8001, 16'h0011},
             '{1'b1, 3'd6, 16'hA5A5, 16'h0010}, '{1'b1, 3'd6, 16'h0002, 16'h0001},
             '{1'b1, 3'd0, 16'hFFFF, 16'h0001}, '{1'b0, 3'd0, 16'h4321, 16'h1234} };
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_op(tbl[i].alu, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1);
      @(negedge clk);
      e = pop_exp();
      last_data = e.data;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL alu[%0d] valid: got %b expected 1", i, out_valid); end
      n_checks++; if (data_out !== e.data) begin n_errors++; $display("FAIL alu[%0d] data: got %h expected %h", i, data_out, e.data); end
      n_checks++; if (address !== e.addr) begin n_errors++; $display("FAIL alu[%0d] addr: got %h expected %h", i, address, e.addr); end
      n_checks++; if (flags !== e.flags) begin n_errors++; $display("FAIL alu[%0d] flags: got %b expected %b", i, flags, e.flags); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL alu_drain valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_mul();
    exp_t e;
    int   bad;
    out_ready = 1'b1;
    drive_op(1'b1, 3'd7, 16'h0003, 16'hFFFE, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL mul_busy: got %0d early-ready/valid cycles expected 0", bad); end
    e = pop_exp();
    last_data = e.data;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mul valid: got %b expected 1", out_valid); end
    n_checks++; if (data_out !== e.data) begin n_errors++; $display("FAIL mul data: got %h expected %h", data_out, e.data); end
    n_checks++; if (address !== e.addr) begin n_errors++; $display("FAIL mul addr: got %h expected %h", address, e.addr); end
    n_checks++; if (flags !== e.flags) begin n_errors++; $display("FAIL mul flags: got %b expected %b", flags, e.flags); end
    // Pass-through back-to-back right after the multiply result.
    drive_op(1'b0, 3'd7, 16'h5555, 16'h1234, 1'b1);
    @(negedge clk);
    e = pop_exp();
    last_data = e.data;
    n_checks++; if (data_out !== e.data) begin n_errors++; $display("FAIL pass data: got %h expected %h", data_out, e.data); end
    n_checks++; if (flags !== e.flags) begin n_errors++; $display("FAIL pass flags: got %b expected %b", flags, e.flags); end
  endtask

  task automatic test_stall();
    exp_t e;
    int   bad;
    out_ready = 1'b0;
    drive_op(1'b1, 3'd0, 16'h0001, 16'h0002, 1'b1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || data_out !== last_data || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    e = pop_exp();
    last_data = e.data;
    n_checks++; if (data_out !== e.data) begin n_errors++; $display("FAIL stall_release data: got %h expected %h", data_out, e.data); end
    n_checks++; if (flags !== e.flags) begin n_errors++; $display("FAIL stall_release flags: got %b expected %b", flags, e.flags); end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_nodup valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    int bad;
    out_ready = 1'b1;
    drive_op(1'b1, 3'd7, 16'h0005, 16'h0007, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    drive_op(1'b1, 3'd0, 16'h0009, 16'h0009, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush valid: got %b expected 0", out_valid); end
    n_checks++; if (flags !== m_flags) begin n_errors++; $display("FAIL flush flags: got %b expected %b", flags, m_flags); end
    n_checks++; if (data_out !== last_data) begin n_errors++; $display("FAIL flush data: got %h expected %h", data_out, last_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush in_ready: got %b expected 1", in_ready); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || data_out !== last_data) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL flush_quiet: got %0d stray cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    out_ready = 1'b1;
    drive_op(1'b1, 3'd7, 16'h1234, 16'h0101, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_flags = 3'b000;
    n_checks++; if (data_out !== 32'h0) begin n_errors++; $display("FAIL rstmul data: got %h expected 0", data_out); end
    n_checks++; if (address !== 32'h0) begin n_errors++; $display("FAIL rstmul addr: got %h expected 0", address); end
    n_checks++; if (flags !== 3'b000) begin n_errors++; $display("FAIL rstmul flags: got %b expected 000", flags); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstmul in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmul valid: got %b expected 0", out_valid); end
    drive_op(1'b1, 3'd0, 16'h0001, 16'h0001, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = pop_exp();
    n_checks++; if (data_out !== e.data) begin n_errors++; $display("FAIL rstmul_after data: got %h expected %h", data_out, e.data); end
    n_checks++; if (flags !== e.flags) begin n_errors++; $display("FAIL rstmul_after flags: got %b expected %b", flags, e.flags); end
    @(negedge clk);
  endtask

  task automatic test_width8();
    int bad;
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_alu = 1'b1; b_op = 3'd0; b_d1 = 8'h7F; b_d2 = 8'h01;
    @(negedge clk);
    n_checks++; if (b_data_out !== 16'hFF80) begin n_errors++; $display("FAIL w8_add data: got %h expected ff80", b_data_out); end
    n_checks++; if (b_address !== 16'h007F) begin n_errors++; $display("FAIL w8_add addr: got %h expected 007f", b_address); end
    n_checks++; if (b_flags !== 3'b010) begin n_errors++; $display("FAIL w8_add flags: got %b expected 010", b_flags); end
    b_op = 3'd7; b_d1 = 8'h0F; b_d2 = 8'h11;
    @(negedge clk);
    b_in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL w8_mul_busy: got %0d early cycles expected 0", bad); end
    n_checks++; if (b_out_valid !== 1'b1) begin n_errors++; $display("FAIL w8_mul valid: got %b expected 1", b_out_valid); end
    n_checks++; if (b_data_out !== 16'hFFFF) begin n_errors++; $display("FAIL w8_mul data: got %h expected ffff", b_data_out); end
    n_checks++; if (b_flags !== 3'b010) begin n_errors++; $display("FAIL w8_mul flags: got %b expected 010", b_flags); end
    @(negedge clk);
  endtask

  initial begin
    flush = 1'b0; in_valid = 1'b0; alu = 1'b0; out_ready = 1'b0;
    op = 3'd0; d1 = 16'h0; d2 = 16'h0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_alu = 1'b0; b_out_ready = 1'b0;
    b_op = 3'd0; b_d1 = 8'h0; b_d2 = 8'h0;
    m_flags = 3'b000;
    last_data = 32'h0;
    rst_n = 1'b0;
    test_reset();
    test_alu();
    test_mul();
    test_stall();
    test_flush();
    test_reset_mid_mul();
    test_width8();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
# exec_unit_mc

Parametrised, registered execution unit for the execute stage of the pipelined processor. It generalises the earlier combinational ADD/NOT/pass-through unit in four ways: configurable operand width, an eight-operation ALU, an iterative multi-cycle multiplier, and registered Z/N/C flags. Valid/ready handshakes and a flush input let the pipeline controller stall and squash it. Outputs are sign-extended to the memory/writeback width, as before.

## Interface
- `WIDTH`, 16: operand and ALU result width (≥ 4, power of 2).
- `OUT_WIDTH`, 32: width of `DataOut` and `Address` (≥ `WIDTH`); values are sign-extended.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Flush`  in  1  synchronous squash of in-flight operation and output.
- `InValid`  in  1  operands/op present.
- `InReady`  out  1  unit can accept this cycle.
- `ALU`  in  1  1 = ALU operation, 0 = pass `Data2`.
- `ALUOp`  in  3  000 ADD, 001 NOT `Data1`, 010 SUB (`Data1` − `Data2`), 011 AND, 100 OR, 101 SHL, 110 SHR (logical), 111 MUL.
- `Data1`, `Data2`  in  `WIDTH`  operands.
- `OutValid`  out  1  `DataOut`/`Address` valid.
- `OutReady`  in  1  downstream consumes this cycle.
- `DataOut`  out  `OUT_WIDTH`  sign-extended result.
- `Address`  out  `OUT_WIDTH`  sign-extended `Data1` of the same operation.
- `Flags`  out  3  {C, N, Z}, registered.

## Operation
- States: IDLE, MUL, HOLD.
- `InReady` = (state == IDLE) or (state == HOLD and `OutReady`). It never depends on `InValid`.
- Accept = `InValid` & `InReady` & !`Flush`.
- A non-MUL accept (or `ALU` = 0) computes the result combinationally and loads the output registers; next state is HOLD and `OutValid` = 1.
- A MUL accept latches the operands and enters MUL for `WIDTH` cycles of shift-add (one multiplier bit per cycle). On the final cycle it loads the output registers and enters HOLD.
- Product = low `WIDTH` bits of `Data1` × `Data2`. These bits are identical for the signed and unsigned interpretations.
- In HOLD:
  - `OutReady` with no new accept → IDLE, `OutValid` = 0.
  - `OutReady` with an accept → back-to-back: the output registers load the new op (or the next state is MUL with `OutValid` = 0).
  - No `OutReady` → outputs held stable.
- Arithmetic is modulo 2^`WIDTH`.
- Shifts use amount `Data2[log2(WIDTH)-1:0]`. The upper bits of `Data2` are ignored.
- Flags update only when the output registers load a result with `ALU` = 1:
  - Z = (result == 0).
  - N = result[`WIDTH`-1].
  - C = carry-out (ADD); borrow, i.e. `Data1` < `Data2` unsigned (SUB); last bit shifted out (SHL/SHR, non-zero amount); unchanged otherwise.
- Pass-through (`ALU` = 0) never changes the flags.
- `Flush`, any state:
  - Next state is IDLE and `OutValid` = 0.
  - An in-progress MUL is abandoned and its flags are not written.
  - `Flush` beats a simultaneous accept.
- Reset, async, any state: state IDLE; `OutValid`, `DataOut`, `Address`, `Flags` = 0; multiplier registers = 0.

## Timing
- Single-cycle op accepted at edge k → `OutValid` = 1 after edge k, so the result is visible in cycle k+1. Latency is 1.
- MUL accepted at edge k → result and `OutValid` after edge k+`WIDTH`. `InReady` = 0 for cycles k+1 … k+`WIDTH`.
- Sustained throughput is one single-cycle op per cycle when `OutReady` is held high.
- `Flags` change on the same edge that `DataOut` loads.
- `DataOut`, `Address` and `Flags` change only on a load edge, a flush (data values retained, only `OutValid` cleared), or reset.

## Test plan
- Reset mid-MUL: assert `rst_n` = 0 at cycle 5 of a MUL → all outputs 0 immediately; after release `InReady` = 1 and state is IDLE.
- ADD 0x7FFF + 0x0001, `WIDTH` = 16 → next cycle `DataOut` = 0xFFFF8000, Flags C = 0, N = 1, Z = 0. Then SUB 0x0003 − 0x0005 → `DataOut` = 0xFFFFFFFE, C = 1, N = 1. Then NOT 0xFFFF → `DataOut` = 0, Z = 1, C = 1 unchanged.
- MUL 0x0003 × 0xFFFE → `InReady` low for 16 cycles; `DataOut` = 0xFFFFFFFA and `OutValid` rise exactly 16 edges after accept. Pass (`ALU` = 0, `Data2` = 0x1234) → `DataOut` = 0x00001234, `Flags` unchanged.
- Stall: hold `OutReady` = 0 for 4 cycles with `InValid` = 1 → outputs stable, no accepts. `OutReady` = 1 → the next op loads on the same edge and no op is lost or duplicated.
- Flush: `Flush` at cycle 3 of a MUL, with `InValid` = 1 in the same cycle → `OutValid` stays 0, `Flags` unchanged, that op not accepted; `InReady` = 1 next cycle.
- SHL 0x8001 by `Data2` = 0x0011 (amount 1) → `DataOut` = 0x00000002, C = 1. SHR by amount 0 → result = `Data1`, C unchanged. Repeat the ADD overflow check with `WIDTH` = 8 and `OUT_WIDTH` = 16.
